// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO multiply/divide sequencer bundle: operation request in, stall/result out.
// master = EX pipeline side, slave = sequencer.
interface hilo_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, annul,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, annul,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for MULT/MULTU/DIV/DIVU: counter-timed multiply, 32-step restoring divide.
// Latency: MUL_LAT cycles (mult), 33 cycles (div); done pulses one cycle with hi/lo valid.
// Backpressure: stall holds EX while busy, drops in DONE or on annul. DIV_ZERO_FAST_EN: b==0 divides finish in 1 cycle.
module hilo_muldiv_ctrl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_DZ = 1'b1;
`else
    localparam bit FAST_DZ = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d;

    logic               accept, op_unsigned;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_c;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   trial, step_rem, step_quo;
    logic               take;

    assign accept      = bus.start & ~bus.annul;
    assign op_unsigned = bus.op[0];

    always_comb begin
        ext_a  = op_unsigned ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
        ext_b  = op_unsigned ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
        prod_c = ext_a * ext_b;
        abs_a  = (!op_unsigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b  = (!op_unsigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // Restoring step: the shifted remainder needs one extra bit before the compare.
    always_comb begin
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        take     = (rem_sh >= {1'b0, dvs_q});
        trial    = rem_sh[WIDTH-1:0] - dvs_q;
        step_rem = take ? trial : rem_sh[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!bus.op[1]) begin
                        prod_d = prod_c;
                        if (MUL_LAT == 1) begin
                            state_d = S_DONE;
                            hi_d    = prod_c[2*WIDTH-1:WIDTH];
                            lo_d    = prod_c[WIDTH-1:0];
                        end else begin
                            cnt_d   = CW'(MUL_LAT - 1);
                            state_d = S_MUL;
                        end
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        qneg_d  = ~op_unsigned & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rneg_d  = ~op_unsigned & bus.a[WIDTH-1];
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = S_DIV;
                        if (FAST_DZ && bus.b == '0) begin
                            state_d = S_DONE;
                            hi_d    = bus.a;
                            lo_d    = '1;
                        end
                    end
                end
            end
            S_MUL: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    hi_d    = prod_q[2*WIDTH-1:WIDTH];
                    lo_d    = prod_q[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (bus.annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CW'(1);
                    // Last step: publish the sign-corrected result straight from the step logic.
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        hi_d    = rneg_q ? -step_rem : step_rem;
                        lo_d    = qneg_q ? -step_quo : step_quo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.stall = ~rst & ~bus.annul &
                       (((state_q == S_IDLE) & bus.start) | (state_q == S_MUL) | (state_q == S_DIV));
    assign bus.done  = (state_q == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
